// File: rtl/vit_seq_pkg.sv
// Shared state encoding and default widths for the Viterbi block sequencer.
package vit_seq_pkg;

  localparam int VS_DATA_W  = 32;
  localparam int VS_CTRL_W  = 32;
  localparam int VS_LEN_W   = 16;
  localparam int VS_TIMEOUT = 4096;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t S_IDLE  = 3'd0;
  localparam seq_state_t S_CTRL  = 3'd1;
  localparam seq_state_t S_FEED  = 3'd2;
  localparam seq_state_t S_DRAIN = 3'd3;
  localparam seq_state_t S_FIN   = 3'd4;

endpackage

// File: rtl/vit_block_sequencer_if.sv
// Host, upstream source and decoder-side channels of the block sequencer.
interface vit_block_sequencer_if
  import vit_seq_pkg::*;
#(
  parameter int DATA_W = VS_DATA_W,
  parameter int CTRL_W = VS_CTRL_W,
  parameter int LEN_W  = VS_LEN_W
) ();

  logic              cfg_start;
  logic [CTRL_W-1:0] cfg_ctrl;
  logic [LEN_W-1:0]  cfg_len;
  logic [LEN_W-1:0]  cfg_exp;

  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;

  logic              m_ctrl_tvalid;
  logic [CTRL_W-1:0] m_ctrl_tdata;
  logic              m_ctrl_tlast;
  logic              m_ctrl_tready;

  logic              m_in_tvalid;
  logic [DATA_W-1:0] m_in_tdata;
  logic              m_in_tlast;
  logic              m_in_tready;

  logic              s_out_tvalid;
  logic              s_out_tdata;
  logic              s_out_tlast;
  logic              s_out_tready;

  logic              bit_valid;
  logic              bit_data;
  logic              busy;
  logic              done;
  logic              err_len;
  logic              err_timeout;
  logic [LEN_W-1:0]  out_count;

  // The sequencer itself
  modport master (
    input  cfg_start, cfg_ctrl, cfg_len, cfg_exp,
    input  src_valid, src_data,
    input  m_ctrl_tready, m_in_tready,
    input  s_out_tvalid, s_out_tdata, s_out_tlast,
    output src_ready,
    output m_ctrl_tvalid, m_ctrl_tdata, m_ctrl_tlast,
    output m_in_tvalid, m_in_tdata, m_in_tlast,
    output s_out_tready,
    output bit_valid, bit_data, busy, done, err_len, err_timeout, out_count
  );

  // Host, source and decoder around it
  modport slave (
    output cfg_start, cfg_ctrl, cfg_len, cfg_exp,
    output src_valid, src_data,
    output m_ctrl_tready, m_in_tready,
    output s_out_tvalid, s_out_tdata, s_out_tlast,
    input  src_ready,
    input  m_ctrl_tvalid, m_ctrl_tdata, m_ctrl_tlast,
    input  m_in_tvalid, m_in_tdata, m_in_tlast,
    input  s_out_tready,
    input  bit_valid, bit_data, busy, done, err_len, err_timeout, out_count
  );

endinterface

// File: rtl/vit_seq_watchdog.sv
// Idle-cycle counter: expires after TIMEOUT consecutive enabled cycles without a clear.
module vit_seq_watchdog
  import vit_seq_pkg::*;
#(
  parameter int TIMEOUT = VS_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int             CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Holds at LIMIT so a stalled enable never wraps back to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_expire = i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/vit_block_sequencer.sv
// Drives one decoding block through the decoder: control word, cfg_len input words,
// then drains decoded bits until output tlast, reporting count and error flags.
module vit_block_sequencer
  import vit_seq_pkg::*;
#(
  parameter int DATA_W  = VS_DATA_W,
  parameter int CTRL_W  = VS_CTRL_W,
  parameter int LEN_W   = VS_LEN_W,
  parameter int TIMEOUT = VS_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  vit_block_sequencer_if.master bus
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_ONE;
  endfunction

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [CTRL_W-1:0] r_ctrl;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_exp;
  logic [LEN_W-1:0]  r_in_cnt;
  logic [LEN_W-1:0]  r_out_cnt;
  logic [LEN_W-1:0]  w_out_cnt_nxt;
  logic              r_bit_valid;
  logic              r_bit_data;
  logic              r_err_len;
  logic              r_err_timeout;
  logic              w_ctrl;
  logic              w_feed;
  logic              w_drain;
  logic              w_start;
  logic              w_ctrl_hs;
  logic              w_in_hs;
  logic              w_in_last;
  logic              w_out_hs;
  logic              w_out_last;
  logic              w_wd_clear;
  logic              w_wd_enable;
  logic              w_expire;
  logic              w_timeout;
  logic [DATA_W-1:0] w_in_data;

  assign w_ctrl  = (r_state == S_CTRL);
  assign w_feed  = (r_state == S_FEED);
  assign w_drain = (r_state == S_DRAIN);

  assign w_start       = (r_state == S_IDLE) && bus.cfg_start && (bus.cfg_len != '0);
  assign w_ctrl_hs     = w_ctrl && bus.m_ctrl_tready;
  assign w_in_hs       = w_feed && bus.src_valid && bus.m_in_tready;
  assign w_in_last     = w_feed && (r_in_cnt == (r_len - LEN_ONE));
  assign w_out_hs      = (w_feed || w_drain) && bus.s_out_tvalid;
  assign w_out_last    = w_out_hs && bus.s_out_tlast;
  assign w_out_cnt_nxt = sat_inc(r_out_cnt);
  assign w_in_data     = bus.src_data;

  // A handshake on the expiring cycle counts as activity, so it wins over the abort
  assign w_timeout   = w_expire && !w_in_hs && !w_out_hs;
  assign w_wd_enable = w_feed || w_drain;
  assign w_wd_clear  = w_in_hs || w_out_hs || (w_state_nxt != r_state);

  vit_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_CTRL;
      S_CTRL:  if (w_ctrl_hs) w_state_nxt = S_FEED;
      S_FEED: begin
        if (w_out_last || w_timeout) begin
          w_state_nxt = S_FIN;
        end else if (w_in_hs && w_in_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (w_out_last || w_timeout) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_bit_valid   <= 1'b0;
      r_bit_data    <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_valid <= w_out_hs;
      if (w_out_hs) begin
        r_bit_data <= bus.s_out_tdata;
      end
      if (w_start) begin
        r_in_cnt      <= '0;
        r_out_cnt     <= '0;
        r_err_len     <= 1'b0;
        r_err_timeout <= 1'b0;
      end else begin
        if (w_in_hs) begin
          r_in_cnt <= r_in_cnt + LEN_ONE;
        end
        if (w_out_hs) begin
          r_out_cnt <= w_out_cnt_nxt;
        end
        // The tlast beat is part of the count being judged
        if (w_out_last && (w_out_cnt_nxt != r_exp)) begin
          r_err_len <= 1'b1;
        end
        if (w_timeout) begin
          r_err_timeout <= 1'b1;
        end
      end
    end
  end

  // Block parameters captured at start; only observed outside IDLE
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_ctrl <= bus.cfg_ctrl;
      r_len  <= bus.cfg_len;
      r_exp  <= bus.cfg_exp;
    end
  end

  assign bus.m_ctrl_tvalid = w_ctrl;
  assign bus.m_ctrl_tdata  = w_ctrl ? r_ctrl : '0;
  assign bus.m_ctrl_tlast  = w_ctrl;

  assign bus.m_in_tvalid = w_feed && bus.src_valid;
  assign bus.m_in_tdata  = w_feed ? w_in_data : '0;
  assign bus.m_in_tlast  = w_in_last;
  assign bus.src_ready   = w_feed && bus.m_in_tready;

  assign bus.s_out_tready = w_feed || w_drain;

  assign bus.bit_valid   = r_bit_valid;
  assign bus.bit_data    = r_bit_data;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_FIN);
  assign bus.err_len     = r_err_len;
  assign bus.err_timeout = r_err_timeout;
  assign bus.out_count   = r_out_cnt;

endmodule

// File: doc/vit_block_sequencer.md
Name: vit_block_sequencer

Overview:
- Sequences one decoding block through the Viterbi decoder's three AXI-stream channels: one control word, then cfg_len input words with tlast on the final word, then drains the decoded bit stream until output tlast.
- Sits between the fault-injection test-vector source and the decoder instance.
- Supplies the decoder-side handshakes and reports completion, output bit count and error flags to the host.

Parameters:
- DATA_W, 32, width of the input-channel tdata and of src_data
- CTRL_W, 32, width of the control-channel tdata
- LEN_W, 16, width of the block-length and output-count fields
- TIMEOUT, 4096, maximum idle cycles in FEED or DRAIN with no handshake before abort

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle pulse; sampled only in IDLE
- cfg_ctrl  in  CTRL_W  control word, latched on start
- cfg_len  in  LEN_W  number of input words, latched on start; 0 is illegal
- cfg_exp  in  LEN_W  expected decoded bit count, latched on start
- src_valid  in  1  upstream input-word valid
- src_data  in  DATA_W  upstream input word
- src_ready  out  1  upstream ready; equals m_in_tready while in FEED, else 0
- m_ctrl_tvalid / m_ctrl_tdata / m_ctrl_tlast  out  1/CTRL_W/1  decoder control channel
- m_ctrl_tready  in  1
- m_in_tvalid / m_in_tdata / m_in_tlast  out  1/DATA_W/1  decoder input channel
- m_in_tready  in  1
- s_out_tvalid / s_out_tdata / s_out_tlast  in  1/1/1  decoder output channel
- s_out_tready  out  1
- bit_valid  out  1  one-cycle strobe per accepted decoded bit
- bit_data  out  1  decoded bit; valid with bit_valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on exit to IDLE
- err_len  out  1  sticky: output count differs from cfg_exp; cleared by next start
- err_timeout  out  1  sticky: timeout abort; cleared by next start
- out_count  out  LEN_W  decoded bits accepted in the current or last block

Behaviour:
- Reset values (rst=0, asynchronous):
  - State IDLE.
  - All outputs 0, including all counters and all sticky flags.
- State machine: IDLE -> CTRL -> FEED -> DRAIN -> FIN -> IDLE.
- IDLE:
  - On cfg_start with cfg_len != 0: latch cfg_ctrl, cfg_len and cfg_exp; clear out_count, err_len and err_timeout; go to CTRL.
  - cfg_start with cfg_len == 0 is ignored; state stays IDLE.
- CTRL:
  - m_ctrl_tvalid=1, m_ctrl_tdata=latched control word, m_ctrl_tlast=1.
  - Go to FEED on the cycle with m_ctrl_tvalid && m_ctrl_tready.
  - No timeout applies in CTRL.
- FEED (combinational pass-through, zero latency):
  - m_in_tvalid=src_valid, m_in_tdata=src_data, src_ready=m_in_tready.
  - in_cnt counts input handshakes.
  - m_in_tlast=1 when in_cnt == len-1.
  - The handshake carrying tlast moves the FSM to DRAIN.
- Output channel during FEED and DRAIN:
  - s_out_tready=1; it is 0 in all other states.
  - Each accepted beat gives bit_valid=1 and bit_data=s_out_tdata one cycle later (registered).
  - Each accepted beat increments out_count; out_count saturates at all-ones.
- DRAIN:
  - Leave on an accepted beat with s_out_tlast=1.
  - On that beat, err_len is set if the final out_count != cfg_exp. The final out_count includes the tlast beat.
- Output tlast during FEED: end the block as in DRAIN and go straight to FIN. Remaining input words are not sent; src_ready=0 from then on.
- FIN: done=1 for one cycle, then IDLE.
- Timeout:
  - idle_cnt is cleared on any input or output handshake and on every state entry.
  - In FEED or DRAIN, when idle_cnt reaches TIMEOUT-1: set err_timeout and go to FIN.
  - Signals done even on abort.
- cfg_start while busy is ignored.
- Reset mid-block returns to IDLE at once. Any beat in flight is dropped; the decoder is reset by the same rst.
- Width rules:
  - in_cnt is LEN_W bits.
  - cfg_len = 2^LEN_W-1 is legal.
  - Comparisons are unsigned.

Decomposition:
- Shared package vit_seq_pkg holds:
  - The state enum: IDLE, CTRL, FEED, DRAIN, FIN.
  - Default widths DATA_W, CTRL_W, LEN_W.
  - The TIMEOUT default.
- One natural sub-module: vit_seq_watchdog, the idle counter. Inputs: clear, enable. Output: expire.
- The FSM, counters and channel muxing stay in the top module.

Test Plan:
- Start with cfg_len=4, cfg_exp=4, ready always high, decoder returns 4 bits 1,0,1,1 with tlast on the 4th -> exactly one ctrl beat, 4 input beats with tlast on beat 4, bit stream 1011, out_count=4, done pulses once, both error flags 0.
- m_in_tready toggled 1,0,1,0 during FEED -> no input word lost or duplicated; tlast still on beat 4; src_ready tracks m_in_tready.
- cfg_exp=5 while decoder returns 3 bits with tlast -> err_len=1, out_count=3, done=1.
- Decoder stalls with m_in_tready=0 after beat 2, TIMEOUT=16 -> err_timeout set after 16 idle cycles, FIN then IDLE, busy drops.
- rst asserted during FEED after 2 beats -> all outputs 0 immediately; a following start with cfg_len=2 completes normally.
- cfg_start with cfg_len=0, and cfg_start while busy -> both ignored: state unchanged, no ctrl beat.
